// File: rtl/approx_prod_accum_if.sv
// ---------------------------------------------------------------------------
// approx_prod_accum_if
// Stream bundle between the approximate multiplier, the accumulator and the
// result consumer.
//   p_valid/p_ready/p_data/p_last : product beat stream into the accumulator
//   out_valid/out_ready           : result handshake
//   out_data/out_terms/out_ovf    : finished sum, term count, overflow flag
// Modports: master = producer/consumer side (testbench or neighbour blocks),
//           slave  = the accumulator itself.
// ---------------------------------------------------------------------------
interface approx_prod_accum_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 7
);
  logic              p_valid;
  logic              p_ready;
  logic [PROD_W-1:0] p_data;
  logic              p_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [CNT_W-1:0]  out_terms;
  logic              out_ovf;

  modport master (
    output p_valid, p_data, p_last, out_ready,
    input  p_ready, out_valid, out_data, out_terms, out_ovf
  );

  modport slave (
    input  p_valid, p_data, p_last, out_ready,
    output p_ready, out_valid, out_data, out_terms, out_ovf
  );
endinterface

// File: rtl/approx_prod_accum.sv
// ---------------------------------------------------------------------------
// approx_prod_accum
// Accumulates unsigned 16-bit approximate products into a dot-product sum.
// A sequence ends on p_last or when MAX_TERMS beats have been taken; the
// finished sum is held in a single registered result slot until taken.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (discards partial sum and result)
//   bus  : approx_prod_accum_if.slave (product stream in, result stream out)
// Optional feature: define ACCUM_SATURATE_EN to clamp the accumulator at
// 2^ACC_W-1 on overflow instead of wrapping modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module approx_prod_accum #(
  parameter int PROD_W    = 16,
  parameter int ACC_W     = 24,
  parameter int MAX_TERMS = 64
) (
  input logic               clk,
  input logic               rst,
  approx_prod_accum_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_TERMS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t            state;
  logic [ACC_W-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              out_valid_q;
  logic [ACC_W-1:0]  out_data_q;
  logic [CNT_W-1:0]  out_terms_q;
  logic              out_ovf_q;

  logic              accept;
  logic              seq_end;
  logic [ACC_W:0]    sum;
  logic [ACC_W:0]    p_ext;
  logic [ACC_W-1:0]  next_acc;
  logic [CNT_W-1:0]  next_count;
  logic              next_ovf;

  // Ready only outside HOLD and never in a reset cycle.
  assign bus.p_ready   = (state != HOLD) & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_terms = out_terms_q;
  assign bus.out_ovf   = out_ovf_q;

  // Next accumulator/count/overflow values for an accepted beat.
  always_comb begin
    accept     = bus.p_valid & bus.p_ready;
    p_ext      = {{(ACC_W + 1 - PROD_W){1'b0}}, bus.p_data};
    sum        = '0;
    next_count = '0;
    next_ovf   = 1'b0;
    if (state == IDLE) begin
      // First beat restarts the sequence; previous acc/ovf are irrelevant.
      sum        = p_ext;
      next_count = CNT_W'(1);
      next_ovf   = 1'b0;
    end else begin
      sum        = {1'b0, acc} + p_ext;
      next_count = count + CNT_W'(1);
      next_ovf   = ovf | sum[ACC_W];
    end
`ifdef ACCUM_SATURATE_EN
    // Once clamped, any further add carries out again, so the clamp sticks.
    if (sum[ACC_W]) begin
      next_acc = {ACC_W{1'b1}};
    end else begin
      next_acc = sum[ACC_W-1:0];
    end
`else
    next_acc = sum[ACC_W-1:0];
`endif
    seq_end = bus.p_last | (next_count == CNT_W'(MAX_TERMS));
  end

  // Sequence FSM with registered result slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_terms_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc   <= next_acc;
            count <= next_count;
            ovf   <= next_ovf;
            if (seq_end) begin
              state       <= HOLD;
              out_valid_q <= 1'b1;
              out_data_q  <= next_acc;
              out_terms_q <= next_count;
              out_ovf_q   <= next_ovf;
            end else begin
              state <= ACCUM;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_approx_prod_accum.sv
// ---------------------------------------------------------------------------
// tb_approx_prod_accum
// Drives two accumulators (ACC_W=24 and ACC_W=18, MAX_TERMS=64) with the same
// stimulus and compares every cycle against a transaction-level model that
// keeps the exact integer sum of each sequence and derives the expected
// wrapped/clamped result and overflow flag from it.
// ---------------------------------------------------------------------------
module tb_approx_prod_accum;
  localparam int MAXT = 64;
  localparam int CW   = $clog2(MAXT + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  approx_prod_accum_if #(.PROD_W(16), .ACC_W(24), .CNT_W(CW)) if_a ();
  approx_prod_accum_if #(.PROD_W(16), .ACC_W(18), .CNT_W(CW)) if_b ();

  approx_prod_accum #(.PROD_W(16), .ACC_W(24), .MAX_TERMS(MAXT)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave));
  approx_prod_accum #(.PROD_W(16), .ACC_W(18), .MAX_TERMS(MAXT)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave));

  int checks   = 0;
  int failures = 0;

  // Reference model state (transaction level).
  bit      m_pend;
  bit      m_inseq;
  longint  m_sum;
  int      m_terms;
  longint  m_res_data [2];
  bit      m_res_ovf  [2];
  int      m_res_terms;
  int      widths     [2] = '{24, 18};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint fold(input longint s, input int w);
    longint lim;
    lim = longint'(1) << w;
`ifdef ACCUM_SATURATE_EN
    return (s >= lim) ? lim - 1 : s;
`else
    return s % lim;
`endif
  endfunction

  // One clock: apply inputs, check outputs at negedge, advance the model.
  task automatic cycle(input bit r, input bit pv, input logic [15:0] pd,
                       input bit pl, input bit ordy, input bit chk);
    bit exp_ready;
    rst = r;
    if_a.p_valid = pv; if_a.p_data = pd; if_a.p_last = pl; if_a.out_ready = ordy;
    if_b.p_valid = pv; if_b.p_data = pd; if_b.p_last = pl; if_b.out_ready = ordy;
    @(negedge clk);
    exp_ready = !m_pend && !r;
    if (chk) begin
      check("a_p_ready",   32'(if_a.p_ready),   32'(exp_ready));
      check("b_p_ready",   32'(if_b.p_ready),   32'(exp_ready));
      check("a_out_valid", 32'(if_a.out_valid), 32'(m_pend));
      check("b_out_valid", 32'(if_b.out_valid), 32'(m_pend));
      check("a_out_data",  32'(if_a.out_data),  32'(m_res_data[0]));
      check("b_out_data",  32'(if_b.out_data),  32'(m_res_data[1]));
      check("a_out_terms", 32'(if_a.out_terms), 32'(m_res_terms));
      check("b_out_terms", 32'(if_b.out_terms), 32'(m_res_terms));
      check("a_out_ovf",   32'(if_a.out_ovf),   32'(m_res_ovf[0]));
      check("b_out_ovf",   32'(if_b.out_ovf),   32'(m_res_ovf[1]));
    end
    if (r) begin
      m_pend = 1'b0; m_inseq = 1'b0; m_sum = 0; m_terms = 0; m_res_terms = 0;
      for (int k = 0; k < 2; k++) begin
        m_res_data[k] = 0;
        m_res_ovf[k]  = 1'b0;
      end
    end else if (m_pend) begin
      if (ordy) m_pend = 1'b0;
    end else if (pv) begin
      if (!m_inseq) begin
        m_sum   = 0;
        m_terms = 0;
      end
      m_sum   = m_sum + longint'(pd);
      m_terms = m_terms + 1;
      if (pl || m_terms == MAXT) begin
        m_pend      = 1'b1;
        m_inseq     = 1'b0;
        m_res_terms = m_terms;
        for (int k = 0; k < 2; k++) begin
          m_res_data[k] = fold(m_sum, widths[k]);
          m_res_ovf[k]  = (m_sum >= (longint'(1) << widths[k]));
        end
      end else begin
        m_inseq = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // Basic sum.
    cycle(1'b0, 1'b1, 16'h0010, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 16'h0020, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 16'h0030, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 16'h0040, 1'b1, 1'b1, 1'b1);
    check("basic_valid", 32'(if_a.out_valid), 32'd1);
    check("basic_data",  32'(if_a.out_data),  32'h0000A0);
    check("basic_terms", 32'(if_a.out_terms), 32'd4);
    check("basic_ovf",   32'(if_a.out_ovf),   32'd0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);
    check("basic_drop",  32'(if_a.out_valid), 32'd0);

    // Term limit, then backpressure with p_valid held high.
    for (int i = 0; i < MAXT; i++) cycle(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b1);
    check("limit_data",  32'(if_a.out_data),  32'd64);
    check("limit_terms", 32'(if_a.out_terms), 32'd64);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 16'h0005, 1'b0, 1'b1, 1'b1);
    check("bp_ready_after", 32'(if_a.p_ready), 32'd1);

    // Overflow on the 18-bit instance (also first beat of this sequence).
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'hFFFF, (i == 4), 1'b0, 1'b1);
    check("ovf_flag", 32'(if_b.out_ovf), 32'd1);
`ifdef ACCUM_SATURATE_EN
    check("ovf_data", 32'(if_b.out_data), 32'h3FFFF);
`else
    check("ovf_data", 32'(if_b.out_data), 32'h0FFFB);
`endif
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);

    // Reset mid-sequence.
    cycle(1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 16'h0100, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 16'h0007, 1'b1, 1'b1, 1'b1);
    check("rst_data",  32'(if_a.out_data),  32'd7);
    check("rst_terms", 32'(if_a.out_terms), 32'd1);
    check("rst_ovf",   32'(if_a.out_ovf),   32'd0);
    cycle(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b1);

    // Single-term, back-to-back.
    cycle(1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    check("single1_data", 32'(if_a.out_data), 32'h00FFFF);
    cycle(1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b1);
    check("single2_data",  32'(if_a.out_data),  32'h000002);
    check("single2_terms", 32'(if_a.out_terms), 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), d,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
